// File: rtl/jtopl_reg_dec_if.sv
// rtl/jtopl_reg_dec_if.sv - CPU write bus interface for the OPL register decoder
//
// Purpose: bundles the CPU-side write port signals.
// Signals:
//   cs_n  chip select, active low
//   wr_n  write strobe, active low
//   addr  0 = address port, 1 = data port
//   din   8-bit CPU data
// Modports: master drives the bus (CPU / testbench), slave samples it (decoder).

interface jtopl_reg_dec_if;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;

    modport master (output cs_n, output wr_n, output addr, output din);
    modport slave  (input  cs_n, input  wr_n, input  addr, input  din);
endinterface

// File: rtl/jtopl_reg_dec.sv
// rtl/jtopl_reg_dec.sv - OPL operator register write decoder and slot counter
//
// Purpose: latches CPU address/data writes, decodes operator register groups
// 0x20/0x40/0x60/0x80 plus slot offset, and runs one full slot rotation
// during which the group update level, the data byte and the per-stage
// slot-match strobes are presented to the operator shift register. Also owns
// the free-running slot counter that defines operator alignment.
//
// Optional build macro: JTOPL_WRQUEUE_EN adds a one-entry queue for valid
// data writes that arrive while a pass is pending or running.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   cen           slot clock enable (one slot advance per cen-high clk)
//   bus           CPU write bus (cs_n, wr_n, addr, din), slave side
//   dout          latched data byte
//   slot          current slot counter, 0..SLOTS-1
//   busy          update pass pending or in progress
//   wr_drop       one-clk pulse when a data write is discarded
//   up_mult       group 0x20 pass active
//   up_ksl_tl     group 0x40 pass active
//   up_ar_dr      group 0x60 pass active
//   up_sl_rr      group 0x80 pass active
//   update_op_I   target slot aligned at stage I
//   update_op_II  target slot aligned at stage II
//   update_op_IV  target slot aligned at stage IV

module jtopl_reg_dec #(
    parameter int SLOTS  = 18,
    parameter int OFF_II = 1,
    parameter int OFF_IV = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    jtopl_reg_dec_if.slave      bus,
    output logic [7:0]          dout,
    output logic [4:0]          slot,
    output logic                busy,
    output logic                wr_drop,
    output logic                up_mult,
    output logic                up_ksl_tl,
    output logic                up_ar_dr,
    output logic                up_sl_rr,
    output logic                update_op_I,
    output logic                update_op_II,
    output logic                update_op_IV
);

    localparam logic [4:0] LP_LAST   = 5'(SLOTS - 1);
    localparam logic [5:0] LP_SLOTS6 = 6'(SLOTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PASS
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_wr_prev;
    logic [7:0] r_addr;
    logic [7:0] r_dout;
    logic [4:0] r_slot;
    logic [4:0] r_pass_cnt;
    logic [1:0] r_grp;
    logic [4:0] r_target;
    logic       r_wr_drop;

`ifdef JTOPL_WRQUEUE_EN
    logic       r_q_valid;
    logic [1:0] r_q_grp;
    logic [4:0] r_q_target;
    logic [7:0] r_q_data;
    logic       w_push;
`endif

    logic       w_wr_lvl;
    logic       w_wr_evt;
    logic       w_addr_wr;
    logic       w_data_ok;
    logic [2:0] w_grp_raw;
    logic [1:0] w_g;
    logic [2:0] w_i;
    logic [4:0] w_target;
    logic [1:0] w_grp_idx;
    logic       w_last;
    logic       w_accept;
    logic       w_q_pop;
    logic       w_drop;
    logic       w_load;
    logic [7:0] w_ld_data;
    logic [1:0] w_ld_grp;
    logic [4:0] w_ld_target;
    logic       w_in_pass;
    logic [5:0] w_sum_ii;
    logic [5:0] w_sum_iv;
    logic [4:0] w_tgt_ii;
    logic [4:0] w_tgt_iv;

    // Write event is the first clk of a cs_n/wr_n low window, so a strobe
    // held low for several clks is still a single write.
    assign w_wr_lvl  = !bus.cs_n && !bus.wr_n;
    assign w_wr_evt  = w_wr_lvl && !r_wr_prev;
    assign w_addr_wr = w_wr_evt && !bus.addr;

    // Address decode from the latched address byte.
    assign w_grp_raw = r_addr[7:5];
    assign w_g       = r_addr[4:3];
    assign w_i       = r_addr[2:0];
    assign w_target  = ({3'b000, w_g} * 5'd6) + {2'b00, w_i};
    assign w_grp_idx = 2'(w_grp_raw - 3'd1);
    assign w_data_ok = w_wr_evt && bus.addr
                       && (w_grp_raw >= 3'd1) && (w_grp_raw <= 3'd4)
                       && (w_g <= 2'd2) && (w_i <= 3'd5);

    assign w_last = (r_state == S_PASS) && cen && (r_pass_cnt == LP_LAST);

    always_comb begin
        w_accept    = 1'b0;
        w_q_pop     = 1'b0;
        w_drop      = 1'b0;
        w_ld_data   = bus.din;
        w_ld_grp    = w_grp_idx;
        w_ld_target = w_target;
`ifdef JTOPL_WRQUEUE_EN
        w_push = 1'b0;
        // The queue drains either at pass exit or, if a write landed in the
        // exit clk itself, on the following IDLE clk.
        w_q_pop  = r_q_valid && (w_last || (r_state == S_IDLE));
        w_accept = w_data_ok && (r_state == S_IDLE) && !r_q_valid;
        w_push   = w_data_ok && !w_accept && !r_q_valid;
        w_drop   = w_data_ok && !w_accept && r_q_valid;
        if (w_q_pop) begin
            w_ld_data   = r_q_data;
            w_ld_grp    = r_q_grp;
            w_ld_target = r_q_target;
        end
`else
        w_accept = w_data_ok && (r_state == S_IDLE);
        w_drop   = w_data_ok && !w_accept;
`endif
    end

    assign w_load = w_accept || w_q_pop;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_load) w_state_nxt = S_ARM;
            S_ARM:  if (cen)    w_state_nxt = S_PASS;
            S_PASS: if (w_last) w_state_nxt = w_q_pop ? S_ARM : S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_prev  <= 1'b0;
            r_addr     <= 8'd0;
            r_dout     <= 8'd0;
            r_slot     <= 5'd0;
            r_pass_cnt <= 5'd0;
            r_grp      <= 2'd0;
            r_target   <= 5'd0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_wr_prev <= w_wr_lvl;
            r_wr_drop <= w_drop;
            if (cen) r_slot <= (r_slot == LP_LAST) ? 5'd0 : r_slot + 5'd1;
            if (w_addr_wr) r_addr <= bus.din;
            if (w_load) begin
                r_dout   <= w_ld_data;
                r_grp    <= w_ld_grp;
                r_target <= w_ld_target;
            end
            if (r_state == S_ARM && cen)       r_pass_cnt <= 5'd0;
            else if (r_state == S_PASS && cen) r_pass_cnt <= r_pass_cnt + 5'd1;
        end
    end

`ifdef JTOPL_WRQUEUE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_valid  <= 1'b0;
            r_q_grp    <= 2'd0;
            r_q_target <= 5'd0;
            r_q_data   <= 8'd0;
        end else if (w_push) begin
            r_q_valid  <= 1'b1;
            r_q_grp    <= w_grp_idx;
            r_q_target <= w_target;
            r_q_data   <= bus.din;
        end else if (w_q_pop) begin
            r_q_valid  <= 1'b0;
        end
    end
`endif

    // Stage offsets wrap around the rotation.
    assign w_sum_ii = {1'b0, r_target} + 6'(OFF_II);
    assign w_sum_iv = {1'b0, r_target} + 6'(OFF_IV);
    assign w_tgt_ii = (w_sum_ii >= LP_SLOTS6) ? 5'(w_sum_ii - LP_SLOTS6) : w_sum_ii[4:0];
    assign w_tgt_iv = (w_sum_iv >= LP_SLOTS6) ? 5'(w_sum_iv - LP_SLOTS6) : w_sum_iv[4:0];

    assign w_in_pass = (r_state == S_PASS);

    assign dout         = r_dout;
    assign slot         = r_slot;
    assign wr_drop      = r_wr_drop;
    assign up_mult      = w_in_pass && (r_grp == 2'd0);
    assign up_ksl_tl    = w_in_pass && (r_grp == 2'd1);
    assign up_ar_dr     = w_in_pass && (r_grp == 2'd2);
    assign up_sl_rr     = w_in_pass && (r_grp == 2'd3);
    assign update_op_I  = w_in_pass && (r_slot == r_target);
    assign update_op_II = w_in_pass && (r_slot == w_tgt_ii);
    assign update_op_IV = w_in_pass && (r_slot == w_tgt_iv);

`ifdef JTOPL_WRQUEUE_EN
    assign busy = (r_state != S_IDLE) || r_q_valid;
`else
    assign busy = (r_state != S_IDLE);
`endif

endmodule
